// File: rtl/icache_pkg.sv
// icache_pkg: geometry constants, FSM state type and word-select helper
// shared by the instruction cache and its line storage.
package icache_pkg;

  localparam int unsigned TAG_W   = 3;
  localparam int unsigned INDEX_W = 3;
  localparam int unsigned LINES   = 8;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WSEL_W  = 2;
  localparam int unsigned MADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  // Pick word w out of a block; word i lives at bits [32i+31:32i].
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [WSEL_W-1:0]  w);
    logic [WORD_W-1:0] res;
    case (w)
      2'd0:    res = blk[31:0];
      2'd1:    res = blk[63:32];
      2'd2:    res = blk[95:64];
      default: res = blk[127:96];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage for the 8-line direct-mapped
// instruction cache.
//   clk       in   clock
//   clear     in   synchronous clear of all valid bits (wins over a write)
//   rd_index  in   combinational read index
//   rd_valid  out  valid bit of the addressed line
//   rd_tag    out  tag of the addressed line
//   rd_data   out  128-bit block of the addressed line
//   wr_en     in   write one line on the rising edge
//   wr_index  in   line to write
//   wr_tag    in   tag to store
//   wr_data   in   block to store
module icache_line_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // Valid bits: the only state that needs a reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, 8 lines x 16 bytes,
// 1 KiB address space. Hits complete in the same cycle; misses stall via
// BUSYWAIT while a block is fetched from instruction memory.
//   CLK           in   clock
//   RESET         in   synchronous active-high reset
//   PC            in   fetch address (only PC[9:2] used)
//   INSTRUCTION   out  fetched word (combinational on a hit, else 0)
//   BUSYWAIT      out  stall request (combinational)
//   mem_read      out  block read request, decoded from the state register
//   mem_address   out  block address PC[9:4] during the read, else 0
//   mem_readdata  in   128-bit block from memory
//   mem_busywait  in   memory still busy
//   hit_count     out  saturating hit counter   (ICACHE_STATS_EN only)
//   miss_count    out  saturating miss counter  (ICACHE_STATS_EN only)
// Optional feature macro: ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         PC,
  output logic [WORD_W-1:0]   INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                mem_read,
  output logic [MADDR_W-1:0]  mem_address,
  input  logic [BLOCK_W-1:0]  mem_readdata,
  input  logic                mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`endif
);

  state_t state, state_n;

  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] pc_index;
  logic [WSEL_W-1:0]  pc_word;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               hit;
  logic               fill;
  logic               busy;
  logic               unused_pc;

  assign pc_tag    = PC[9:7];
  assign pc_index  = PC[6:4];
  assign pc_word   = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  icache_line_array u_lines (
    .clk      (CLK),
    .clear    (RESET),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_index (pc_index),
    .wr_tag   (pc_tag),
    .wr_data  (mem_readdata)
  );

  assign hit = line_valid && (line_tag == pc_tag);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and request decode.
  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    fill        = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          busy    = 1'b1;
          state_n = MEM_READ;
        end
      end
      MEM_READ: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = PC[9:4];
        if (!mem_busywait) begin
          state_n = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        fill    = !RESET;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // CPU-facing outputs are quiet while RESET is held.
  assign BUSYWAIT    = busy && !RESET;
  assign INSTRUCTION = (state == IDLE && hit && !RESET) ? word_sel(line_data, pc_word)
                                                       : '0;

`ifdef ICACHE_STATS_EN
  logic just_filled;

  // The hit right after a refill completes the missed fetch; not counted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      just_filled <= 1'b0;
    end else begin
      just_filled <= (state == UPDATE);
    end
  end

  // Saturating hit/miss counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (hit && !just_filled && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (!hit && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
